icache_axi_rd_bridge: RTL and testbench

- Responder end of the icache miss-fill request interface (req_ena / req_addr out, rsp_data / rsp_valid back).
- Converts each held refill request into one single-beat AXI4 read (AR + R channels) and returns the 64-bit beat to the icache as a one-cycle response pulse.
- Sits between the icache and the top-level AXI arbiter/crossbar.
- Also reports per-transaction error status and miss latency for performance counters.

---
 rtl/icache_axi_rd_bridge_pkg.sv | 17 +
 rtl/icache_axi_rd_bridge_sat_counter.sv | 22 ++
 rtl/icache_axi_rd_bridge.sv | 105 ++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared AXI constants and FSM state encoding for the icache refill read bridge.
package icache_axi_rd_bridge_pkg;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [2:0] SIZE_8B        = 3'b011;
  localparam logic [7:0] LEN_1BEAT      = 8'd0;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

endpackage

// File: rtl/icache_axi_rd_bridge_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module icache_axi_rd_bridge_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// Turns each held icache refill request into one single-beat AXI4 read and
// returns the beat as a one-cycle response pulse with error and latency status.
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT,
  parameter int         LAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ena,
  input  logic [63:0]       req_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic              busy,
  output logic [LAT_W-1:0]  last_lat,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);

  state_t           state;
  state_t           state_nx;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             beat_match;
  logic             unused_addr;

  // Upper address bits and the byte offset are intentionally discarded.
  assign unused_addr = &{1'b0, req_addr};

  assign accept     = (state == ST_IDLE) && req_ena;
  assign beat_match = (state == ST_R) && rvalid && (rid == AXI_ID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req_ena) state_nx = ST_AR;
      ST_AR:   if (arready) state_nx = ST_R;
      ST_R:    if (beat_match) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A matching beat without rlast means the slave ignored arlen=0; flag it but keep the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      last_lat <= '0;
    end else begin
      if (accept) begin
        araddr <= {req_addr[ADDR_W-1:3], 3'b000};
      end
      if (beat_match) begin
        rsp_data <= rdata;
        rsp_err  <= (rresp != RESP_OKAY) || !rlast;
      end
      if (state == ST_DONE) begin
        last_lat <= lat_cnt;
      end
    end
  end

  icache_axi_rd_bridge_sat_counter #(.W(LAT_W)) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable ((state == ST_AR) || (state == ST_R)),
    .count  (lat_cnt)
  );

  assign arvalid   = (state == ST_AR);
  assign rready    = (state == ST_R);
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign arid      = AXI_ID;
  assign arlen     = LEN_1BEAT;
  assign arsize    = SIZE_8B;
  assign arburst   = BURST_INCR;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Randomized bench for icache_axi_rd_bridge: a scripted AXI slave plus a per-transaction
// reference model of address, data, error and latency.
module tb_icache_axi_rd_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LAT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_ena = 1'b0;
  logic [63:0]       req_addr = '0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_valid;
  logic              rsp_err;
  logic              busy;
  logic [LAT_W-1:0]  last_lat;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b0;
  logic [3:0]        rid = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [LAT_W-1:0] exp_last_lat = '0;
  logic [63:0]      exp_rsp_data = '0;
  bit               hist_valid   = 1'b0;

  icache_axi_rd_bridge dut (
    .clk(clk), .rst(rst), .req_ena(req_ena), .req_addr(req_addr),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy),
    .last_lat(last_lat), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic check_idle(input string name);
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0)
      $display("[TB] FAIL %s_idle: busy=%b rsp_valid=%b arvalid=%b rready=%b, expected all 0",
               name, busy, rsp_valid, arvalid, rready);
    else n_pass++;
    if (hist_valid) begin
      n_checks++;
      if (last_lat !== exp_last_lat)
        $display("[TB] FAIL %s_last_lat: got %0d expected %0d", name, last_lat, exp_last_lat);
      else n_pass++;
      n_checks++;
      if (rsp_data !== exp_rsp_data)
        $display("[TB] FAIL %s_rsp_data_hold: got %h expected %h", name, rsp_data, exp_rsp_data);
      else n_pass++;
    end
  endtask

  // One refill: ar_delay cycles of arready low, then gap idle R cycles, nforeign
  // beats with a foreign rid, then the matching beat.
  task automatic run_txn(input logic [63:0] addr, input int ar_delay, input int gap,
                         input int nforeign, input logic [63:0] data,
                         input logic [1:0] resp, input logic last, input string name);
    logic [31:0] exp_addr;
    int          lat_exp;
    int          lat_obs;
    int          cyc;
    int          ar_wait;
    int          r_slot;
    int          ar_issues;
    int          first_ar_cyc;
    bit          done;
    bit          ar_bad;
    logic        prev_arvalid;
    logic        prev_arready;
    exp_addr = addr[31:0] & ~32'h7;
    lat_exp  = (ar_delay + 1) + (gap + nforeign + 1);
    @(negedge clk);
    check_idle(name);
    req_ena  = 1'b1;
    req_addr = addr;
    lat_obs = 0; cyc = 0; ar_wait = 0; r_slot = 0; ar_issues = 0; first_ar_cyc = -1;
    done = 1'b0; ar_bad = 1'b0; prev_arvalid = 1'b0; prev_arready = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_addr = {$urandom, $urandom};
      if (arvalid && !prev_arvalid) begin
        ar_issues++;
        if (first_ar_cyc < 0) first_ar_cyc = cyc;
      end
      if (prev_arvalid && !prev_arready && !arvalid) ar_bad = 1'b1;
      if (arvalid && araddr !== exp_addr) ar_bad = 1'b1;
      if (busy && !rsp_valid) lat_obs++;
      if (rsp_valid) begin
        done = 1'b1;
        n_checks++;
        if (rsp_data !== data)
          $display("[TB] FAIL %s_rsp_data: got %h expected %h", name, rsp_data, data);
        else n_pass++;
        n_checks++;
        if (rsp_err !== ((resp != 2'b00) || !last))
          $display("[TB] FAIL %s_rsp_err: got %b expected %b", name, rsp_err,
                   (resp != 2'b00) || !last);
        else n_pass++;
        req_ena = 1'b0;
      end
      prev_arvalid = arvalid;
      if (arvalid) begin
        arready = (ar_wait >= ar_delay);
        ar_wait++;
      end else arready = 1'b0;
      prev_arready = arready;
      if (rready) begin
        if (r_slot < gap) begin
          rvalid = 1'b0;
        end else if (r_slot < gap + nforeign) begin
          rvalid = 1'b1;
          rid    = 4'($urandom_range(1, 15));
          rdata  = {$urandom, $urandom};
          rresp  = 2'($urandom_range(0, 3));
          rlast  = 1'b1;
        end else begin
          rvalid = 1'b1;
          rid    = 4'h0;
          rdata  = data;
          rresp  = resp;
          rlast  = last;
        end
        r_slot++;
      end else rvalid = 1'b0;
    end
    n_checks++;
    if (!done) $display("[TB] FAIL %s_timeout: got no rsp_valid in %0d cycles, expected one", name, cyc);
    else n_pass++;
    n_checks++;
    if (ar_bad) $display("[TB] FAIL %s_araddr: araddr/arvalid unstable or wrong, expected %h", name, exp_addr);
    else n_pass++;
    n_checks++;
    if (ar_issues != 1) $display("[TB] FAIL %s_ar_count: got %0d AR issues, expected 1", name, ar_issues);
    else n_pass++;
    n_checks++;
    if (first_ar_cyc != 1) $display("[TB] FAIL %s_ar_cycle: arvalid at cycle %0d, expected 1", name, first_ar_cyc);
    else n_pass++;
    n_checks++;
    if (lat_obs != lat_exp || cyc != lat_exp + 1)
      $display("[TB] FAIL %s_latency: got busy=%0d rsp_cycle=%0d expected %0d/%0d",
               name, lat_obs, cyc, lat_exp, lat_exp + 1);
    else n_pass++;
    exp_last_lat = LAT_W'(lat_exp);
    exp_rsp_data = data;
    hist_valid   = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL reset_ctrl: arvalid=%b rready=%b rsp_valid=%b busy=%b, expected 0",
               arvalid, rready, rsp_valid, busy);
    else n_pass++;
    n_checks++;
    if (rsp_data !== 64'h0 || rsp_err !== 1'b0 || araddr !== 32'h0 || last_lat !== 16'h0)
      $display("[TB] FAIL reset_regs: rsp_data=%h rsp_err=%b araddr=%h last_lat=%0d, expected 0",
               rsp_data, rsp_err, araddr, last_lat);
    else n_pass++;
    n_checks++;
    if (arid !== 4'h0 || arlen !== 8'h0 || arsize !== 3'b011 || arburst !== 2'b01)
      $display("[TB] FAIL reset_ar_const: arid=%h arlen=%h arsize=%b arburst=%b, expected 0/0/011/01",
               arid, arlen, arsize, arburst);
    else n_pass++;
    rst = 1'b1;
    hist_valid = 1'b1;
  endtask

  task automatic test_single_miss();
    run_txn(64'h8000_0104, 0, 0, 0, 64'hDEAD_BEEF_0000_1111, 2'b00, 1'b1, "single_miss");
  endtask

  task automatic test_ar_backpressure();
    run_txn(64'h0000_1234_0000_2238, 5, 0, 0, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b1, "ar_backpressure");
  endtask

  task automatic test_foreign_rid();
    run_txn(64'h0000_0000_4000_0010, 0, 0, 1, 64'h1, 2'b00, 1'b1, "foreign_rid");
  endtask

  task automatic test_error_resp();
    run_txn(64'h0000_0000_1000_0020, 1, 1, 0, 64'hA5A5_A5A5_5A5A_5A5A, 2'b10, 1'b1, "slverr");
    run_txn(64'h0000_0000_1000_0028, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0, "no_rlast");
  endtask

  task automatic test_back_to_back();
    run_txn(64'h0000_0000_2000_0040, 0, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 1'b1, "b2b_first");
    run_txn(64'h0000_0000_3000_0087, 0, 0, 0, 64'h5555_6666_7777_8888, 2'b00, 1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid_r();
    @(negedge clk);
    check_idle("mid_r_pre");
    req_ena  = 1'b1;
    req_addr = 64'h0000_0000_5000_0100;
    @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b0;
    n_checks++;
    if (rready !== 1'b1) $display("[TB] FAIL mid_r_rready: got %b expected 1", rready);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (rready !== 1'b0 || arvalid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL mid_r_async: rready=%b arvalid=%b rsp_valid=%b busy=%b, expected 0",
               rready, arvalid, rsp_valid, busy);
    else n_pass++;
    @(negedge clk);
    req_ena = 1'b0;
    rst     = 1'b1;
    exp_last_lat = '0;
    exp_rsp_data = '0;
    hist_valid   = 1'b1;
    run_txn(64'h8000_0104, 0, 0, 0, 64'hDEAD_BEEF_0000_1111, 2'b00, 1'b1, "post_reset_miss");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn({$urandom, $urandom}, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), {$urandom, $urandom},
              ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom_range(0, 4) != 0), $sformatf("rand%0d", i));
    end
    @(negedge clk);
    check_idle("final");
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_ar_backpressure();
    test_foreign_rid();
    test_error_resp();
    test_back_to_back();
    test_reset_mid_r();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
